ifetch_responder: RTL and testbench

//  Instruction-side responder for the single-cycle core's pc block: takes the PC fetch

---
 rtl/ifetch_responder_if.sv | 34 +++
 rtl/ifetch_responder.sv | 104 ++++++++++
 tb/tb_ifetch_responder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_responder_if.sv
// Fetch-side handshake and instruction memory bus
// bundled between the pc block, the responder and memory.
interface ifetch_responder_if;
  logic        fetch_en;
  logic [31:0] PCaddr;
  logic        flush;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic        iready;
  logic [31:0] instr;
  logic        misalign_err;
  logic        bus_err;
  logic [15:0] hit_count;

  modport slave (
    input  fetch_en, PCaddr, flush,
    input  mem_rdata, mem_busy,
    output mem_ren, mem_addr,
    output iready, instr,
    output misalign_err, bus_err,
    output hit_count
  );

  modport master (
    output fetch_en, PCaddr, flush,
    output mem_rdata, mem_busy,
    input  mem_ren, mem_addr,
    input  iready, instr,
    input  misalign_err, bus_err,
    input  hit_count
  );
endinterface

// File: rtl/ifetch_responder.sv
// Instruction fetch responder: one-entry buffer,
// misalign and bus-timeout reporting, iready pulse.
module ifetch_responder #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic               clk,
  input logic               nRST,
  ifetch_responder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            buf_valid;
  logic [31:0]     buf_addr;
  logic [31:0]     buf_instr;
  logic [15:0]     hit_cnt;
  logic            misal;
  logic            hit;

  assign misal = |bus.PCaddr[1:0];
  assign hit   = buf_valid && (bus.PCaddr == buf_addr)
               && !bus.flush;

  assign bus.hit_count = hit_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state            <= IDLE;
      cnt              <= '0;
      buf_valid        <= 1'b0;
      buf_addr         <= '0;
      buf_instr        <= '0;
      hit_cnt          <= '0;
      bus.iready       <= 1'b0;
      bus.instr        <= NOP_INSTR;
      bus.mem_ren      <= 1'b0;
      bus.mem_addr     <= '0;
      bus.misalign_err <= 1'b0;
      bus.bus_err      <= 1'b0;
    end else begin
      bus.iready       <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.bus_err      <= 1'b0;
      if (bus.flush) buf_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.fetch_en) begin
            unique case (1'b1)
              misal: begin
                state            <= RESP;
                bus.iready       <= 1'b1;
                bus.instr        <= NOP_INSTR;
                bus.misalign_err <= 1'b1;
              end
              hit: begin
                state      <= RESP;
                bus.iready <= 1'b1;
                bus.instr  <= buf_instr;
                if (hit_cnt != 16'hFFFF)
                  hit_cnt <= hit_cnt + 16'd1;
              end
              default: begin
                state        <= FETCH;
                bus.mem_ren  <= 1'b1;
                bus.mem_addr <= bus.PCaddr;
                cnt          <= '0;
              end
            endcase
          end
        end
        FETCH: begin
          if (!bus.mem_busy) begin
            state       <= RESP;
            bus.iready  <= 1'b1;
            bus.instr   <= bus.mem_rdata;
            bus.mem_ren <= 1'b0;
            buf_instr   <= bus.mem_rdata;
            buf_addr    <= bus.mem_addr;
            // a concurrent flush keeps the entry invalid
            if (!bus.flush) buf_valid <= 1'b1;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state       <= RESP;
            bus.iready  <= 1'b1;
            bus.instr   <= NOP_INSTR;
            bus.bus_err <= 1'b1;
            bus.mem_ren <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: miss/hit,
// misalign, timeout, flush, async reset, saturation.
module tb_ifetch_responder;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk  = 1'b0;
  logic nRST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ifetch_responder_if bus();

  ifetch_responder dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    bus.fetch_en  = 1'b0;
    bus.PCaddr    = '0;
    bus.flush     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_busy  = 1'b0;
    #2 nRST = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.iready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_iready got %b want 0", bus.iready);
    end
    n_cmp++;
    if (bus.instr !== NOP) begin
      n_err++;
      $display("FAIL rst_instr got %h want %h", bus.instr, NOP);
    end
    n_cmp++;
    if (bus.mem_ren !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mem got %b/%h want 0/0",
               bus.mem_ren, bus.mem_addr);
    end
    n_cmp++;
    if (bus.misalign_err !== 1'b0 || bus.bus_err !== 1'b0
        || bus.hit_count !== 16'h0) begin
      n_err++;
      $display("FAIL rst_flags got %b/%b/%h want 0/0/0",
               bus.misalign_err, bus.bus_err, bus.hit_count);
    end
    nRST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_hit;
    bus.fetch_en = 1'b1;
    bus.PCaddr   = 32'h40;
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h40) begin
        n_err++;
        $display("FAIL miss_ren%0d got %b/%h want 1/00000040",
                 i, bus.mem_ren, bus.mem_addr);
      end
      // dropping fetch_en and moving PC mid-fetch must not matter
      if (i == 1) begin
        bus.fetch_en = 1'b0;
        bus.PCaddr   = 32'h80;
      end
      bus.mem_busy  = (i < 3);
      bus.mem_rdata = (i == 3) ? 32'h00500093 : 32'hDEADBEEF;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.instr !== 32'h00500093
        || bus.mem_ren !== 1'b0) begin
      n_err++;
      $display("FAIL miss_resp got %b/%h/%b want 1/00500093/0",
               bus.iready, bus.instr, bus.mem_ren);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.iready !== 1'b0 || bus.instr !== 32'h00500093) begin
      n_err++;
      $display("FAIL miss_pulse got %b/%h want 0/00500093",
               bus.iready, bus.instr);
    end
    bus.fetch_en  = 1'b1;
    bus.PCaddr    = 32'h40;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.instr !== 32'h00500093
        || bus.mem_ren !== 1'b0 || bus.hit_count !== 16'd1) begin
      n_err++;
      $display("FAIL hit got %b/%h/%b/%0d want 1/00500093/0/1",
               bus.iready, bus.instr, bus.mem_ren, bus.hit_count);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    bus.fetch_en = 1'b1;
    bus.PCaddr   = 32'h42;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.misalign_err !== 1'b1
        || bus.instr !== NOP || bus.mem_ren !== 1'b0) begin
      n_err++;
      $display("FAIL misalign got %b/%b/%h/%b want 1/1/%h/0",
               bus.iready, bus.misalign_err, bus.instr,
               bus.mem_ren, NOP);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.misalign_err !== 1'b0 || bus.iready !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_clr got %b/%b want 0/0",
               bus.misalign_err, bus.iready);
    end
  endtask

  task automatic test_timeout;
    int  ren_cycles;
    logic seen;
    ren_cycles   = 0;
    seen         = 1'b0;
    bus.fetch_en = 1'b1;
    bus.PCaddr   = 32'h100;
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus.fetch_en = 1'b0;
      if (bus.iready === 1'b1) seen = 1'b1;
      else if (bus.mem_ren === 1'b1) ren_cycles++;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL to_iready got none want pulse in 40 cycles");
    end
    n_cmp++;
    if (ren_cycles != 16) begin
      n_err++;
      $display("FAIL to_ren_cycles got %0d want 16", ren_cycles);
    end
    n_cmp++;
    if (bus.bus_err !== 1'b1 || bus.instr !== NOP
        || bus.mem_ren !== 1'b0) begin
      n_err++;
      $display("FAIL to_resp got %b/%h/%b want 1/%h/0",
               bus.bus_err, bus.instr, bus.mem_ren, NOP);
    end
    @(negedge clk);
    bus.fetch_en  = 1'b1;
    bus.mem_busy  = 1'b0;
    bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.mem_ren !== 1'b1) begin
      n_err++;
      $display("FAIL to_refetch_miss got %b want 1", bus.mem_ren);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.instr !== 32'h11111111
        || bus.bus_err !== 1'b0 || bus.hit_count !== 16'd1) begin
      n_err++;
      $display("FAIL to_refetch got %b/%h/%b/%0d want 1/11111111/0/1",
               bus.iready, bus.instr, bus.bus_err, bus.hit_count);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bus.fetch_en  = 1'b1;
    bus.PCaddr    = 32'h40;
    bus.mem_busy  = 1'b0;
    bus.mem_rdata = 32'h00500093;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.fetch_en  = 1'b1;
    bus.mem_rdata = 32'h22222222;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.mem_ren !== 1'b1 || bus.hit_count !== 16'd1) begin
      n_err++;
      $display("FAIL flush_miss got %b/%0d want 1/1",
               bus.mem_ren, bus.hit_count);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.instr !== 32'h22222222) begin
      n_err++;
      $display("FAIL flush_capture got %b/%h want 1/22222222",
               bus.iready, bus.instr);
    end
    @(negedge clk);
    bus.fetch_en  = 1'b1;
    bus.mem_rdata = 32'h33333333;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.mem_ren !== 1'b1 || bus.iready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_cap_miss got %b/%b want 1/0",
               bus.mem_ren, bus.iready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.instr !== 32'h33333333
        || bus.hit_count !== 16'd1) begin
      n_err++;
      $display("FAIL flush_refill got %b/%h/%0d want 1/33333333/1",
               bus.iready, bus.instr, bus.hit_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bus.fetch_en = 1'b1;
    bus.PCaddr   = 32'h200;
    bus.mem_busy = 1'b1;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.mem_ren !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre got %b want 1", bus.mem_ren);
    end
    #2 nRST = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_ren !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async got %b want 0", bus.mem_ren);
    end
    bus.mem_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.iready !== 1'b0 || bus.hit_count !== 16'h0
        || bus.instr !== NOP) begin
      n_err++;
      $display("FAIL rstmid_hold got %b/%0d/%h want 0/0/%h",
               bus.iready, bus.hit_count, bus.instr, NOP);
    end
    nRST = 1'b1;
    @(negedge clk);
    bus.fetch_en  = 1'b1;
    bus.PCaddr    = 32'h40;
    bus.mem_rdata = 32'h44444444;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.mem_ren !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_empty got %b want 1", bus.mem_ren);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_saturation;
    force dut.hit_cnt = 16'hFFFE;
    #1 release dut.hit_cnt;
    bus.fetch_en  = 1'b1;
    bus.PCaddr    = 32'h40;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.instr !== 32'h44444444
        || bus.hit_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hit got %b/%h/%h want 1/44444444/ffff",
               bus.iready, bus.instr, bus.hit_count);
    end
    @(negedge clk);
    bus.fetch_en = 1'b1;
    @(negedge clk);
    bus.fetch_en = 1'b0;
    n_cmp++;
    if (bus.iready !== 1'b1 || bus.hit_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hold got %b/%h want 1/ffff",
               bus.iready, bus.hit_count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
